maze_collision_detector: RTL and testbench
==========================================

# maze_collision_detector

Consumes the per-pixel `wall[17:0]` hit vector from the level wall generator, together with the same `xCount`/`yCount` scan and the player position. Tests each scanned pixel against the player's box and accumulates wall overlaps over a whole frame. Commits a per-frame collision result on each `update` edge and runs the lives counter and game-over latch for the game-state logic downstream.

## Interface
Parameters:
- `NUM_WALLS`, 18: width of the wall vector.
- `PLAYER_SIZE`, 10'd10: player box edge length in pixels.
- `LIVES`, 3: lives loaded at reset (1..7).

Ports:
- `clk`  in  1  pixel clock; the wall generator's register stage runs on the same clock.
- `rst`  in  1  synchronous, active-high reset.
- `update`  in  1  frame-tick level, sampled on `clk`; its rising edge marks frame end.
- `xCount`  in  10  current scan column.
- `yCount`  in  10  current scan row.
- `wall`  in  NUM_WALLS  per-wall pixel hit, registered one `clk` after `xCount`/`yCount`.
- `player_x`  in  10  player box origin column; held stable within a frame.
- `player_y`  in  10  player box origin row; held stable within a frame.
- `player_px`  out  1  pixel is inside the player box; aligned with `wall`, for the display mux.
- `collide`  out  1  last committed frame had at least one player/wall overlap.
- `hit_mask`  out  NUM_WALLS  walls overlapped in the last committed frame.
- `hit_index`  out  5  lowest set bit of `hit_mask`; 5'd31 when none.
- `lives`  out  3  remaining lives.
- `game_over`  out  1  lives exhausted; sticky until `rst`.

## Operation
- Player box test uses strict bounds, the same convention as the walls: `xCount > player_x && xCount < player_x+PLAYER_SIZE`, and likewise for y.
- Sums are 10-bit and wrap mod 1024, with no saturation.
- `player_px` is registered, so it lines up with `wall`.
- Hit term each cycle: `wall & {NUM_WALLS{player_px}}`.
- Accumulator `acc_mask` ORs in the hit term every cycle while in RUN.
- Edge detector: `upd_q` holds the previous `update`; edge = `update & ~upd_q`.
- FSM states:
  - RUN: accumulate; on edge go to COMMIT.
  - COMMIT (one cycle):
    - `hit_mask` <= `acc_mask`; `collide` <= |`acc_mask`; `hit_index` <= priority encode.
    - `acc_mask` <= the current cycle's hit term, so no pixel is lost.
    - If the new collide is 1, the previous `collide` is 0 and `lives` > 0, then `lives` decrements.
    - If the decrement reaches 0, go to OVER; otherwise go to RUN.
  - OVER: `game_over` = 1; all result outputs frozen, accumulation disabled, further `update` edges ignored. Only `rst` exits.
- A collision sustained across consecutive frames costs one life only; it must clear for a full committed frame before another life can be lost.
- Edge arriving in COMMIT is impossible, because the edge needs `update` low then high. A two-cycle pulse gives one edge.

## Timing
- Reset values:
  - state RUN, `acc_mask` 0, `upd_q` 1 (no spurious commit if `update` is high at reset release).
  - `player_px` 0, `collide` 0, `hit_mask` 0, `hit_index` 31, `lives` LIVES, `game_over` 0.
- Scan to hit: counts at cycle t feed `player_px` and `wall` at t+1, and `acc_mask` at t+2.
- Frame end to result: `update` rises at cycle e, so COMMIT is at e+1. `collide`/`hit_mask`/`hit_index`/`lives` are valid at e+2, and `game_over` at e+2 when the last life is lost.
- Reset mid-frame discards the accumulator; the first commit after reset covers only post-reset pixels.
- `rst` takes priority over all state, including OVER.

## Structure
- Shared package `maze_pkg`:
  - state enum `coll_state_t` {RUN, COMMIT, OVER}
  - `NUM_WALLS` = 18
  - `SCREEN_W` = 640, `SCREEN_H` = 480
  - `NO_HIT` = 5'd31
- Sub-module `wall_priority_enc`: combinational NUM_WALLS-to-5 lowest-set-bit encoder, used by COMMIT.
- Everything else is flat in one module.

## Test plan
- Scan a frame with player (300,100) and an injected `wall[1]` hit at (305,105), then pulse `update` -> at e+2 `collide`=1, `hit_mask`=18'h2, `hit_index`=1, `lives`=2.
- Scan three consecutive frames with the same overlap -> `lives` stays 2 after frames 2 and 3; a clear frame followed by a hit frame -> `lives`=1.
- Inject hits on walls 4 and 9 in one frame -> `hit_mask`=18'h210, `hit_index`=4, and a single life lost.
- Lose 3 lives across separated hit frames -> `game_over`=1 with `lives`=0; further hit frames leave `lives`=0 and `hit_mask` unchanged.
- Set `player_x`=1020 (wraps) with wall hits at x=2..5 -> no `player_px` and `collide`=0; check a wall pixel exactly on box edge x=300 -> not counted.
- Hold `update` high through `rst` release, assert `rst` mid-frame after a hit, and hold `update` high for 2 cycles -> no commit at release, the pre-reset hit is discarded, and exactly one COMMIT occurs for the 2-cycle pulse.

Source files
------------

// File: rtl/maze_pkg.sv
//------------------------------------------------------------------------------
// maze_pkg : shared types and constants for the maze collision logic
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package maze_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    COMMIT = 2'd1,
    OVER   = 2'd2
  } coll_state_t;

  localparam int         NUM_WALLS = 18;
  localparam int         SCREEN_W  = 640;
  localparam int         SCREEN_H  = 480;
  localparam logic [4:0] NO_HIT    = 5'd31;

endpackage

`default_nettype wire

// File: rtl/wall_priority_enc.sv
//------------------------------------------------------------------------------
// wall_priority_enc : lowest-set-bit encoder, NO_HIT when the mask is empty
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wall_priority_enc #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [4:0]       index_o
);
  import maze_pkg::*;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    index_o = NO_HIT;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i]) index_o = 5'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/maze_collision_detector.sv
//------------------------------------------------------------------------------
// maze_collision_detector : per-frame player/wall overlap, lives and game over
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module maze_collision_detector #(
  parameter int         NUM_WALLS   = 18,
  parameter logic [9:0] PLAYER_SIZE = 10'd10,
  parameter int         LIVES       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update,
  input  logic [9:0]           xCount,
  input  logic [9:0]           yCount,
  input  logic [NUM_WALLS-1:0] wall,
  input  logic [9:0]           player_x,
  input  logic [9:0]           player_y,
  output logic                 player_px,
  output logic                 collide,
  output logic [NUM_WALLS-1:0] hit_mask,
  output logic [4:0]           hit_index,
  output logic [2:0]           lives,
  output logic                 game_over
);
  import maze_pkg::*;

  coll_state_t          state_q, state_d;
  logic [NUM_WALLS-1:0] acc_mask_q, acc_mask_d;
  logic [NUM_WALLS-1:0] hit_mask_q, hit_mask_d;
  logic [4:0]           hit_index_q, hit_index_d;
  logic [2:0]           lives_q, lives_d;
  logic                 collide_q, collide_d;
  logic                 game_over_q, game_over_d;
  logic                 upd_q;
  logic                 player_px_q;

  logic [9:0]           w_x_end, w_y_end;
  logic                 w_in_box, w_edge;
  logic [NUM_WALLS-1:0] w_hit;
  logic [4:0]           w_enc;

  // Box ends wrap mod 1024, so a box near the right edge matches nothing.
  always_comb begin
    w_x_end  = player_x + PLAYER_SIZE;
    w_y_end  = player_y + PLAYER_SIZE;
    w_in_box = (xCount > player_x) && (xCount < w_x_end) &&
               (yCount > player_y) && (yCount < w_y_end);
    w_hit    = wall & {NUM_WALLS{player_px_q}};
    w_edge   = update & ~upd_q;
  end

  wall_priority_enc #(
    .WIDTH (NUM_WALLS)
  ) u_enc (
    .mask_i  (acc_mask_q),
    .index_o (w_enc)
  );

  always_comb begin
    state_d     = state_q;
    acc_mask_d  = acc_mask_q;
    hit_mask_d  = hit_mask_q;
    hit_index_d = hit_index_q;
    collide_d   = collide_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    case (state_q)
      RUN: begin
        acc_mask_d = acc_mask_q | w_hit;
        if (w_edge) state_d = COMMIT;
      end
      COMMIT: begin
        hit_mask_d  = acc_mask_q;
        collide_d   = |acc_mask_q;
        hit_index_d = w_enc;
        acc_mask_d  = w_hit;
        state_d     = RUN;
        // Only a fresh collision (clear frame before it) costs a life.
        if (collide_d && !collide_q && (lives_q != 3'd0)) begin
          lives_d = lives_q - 3'd1;
          if (lives_d == 3'd0) begin
            state_d     = OVER;
            game_over_d = 1'b1;
          end
        end
      end
      OVER: begin
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      acc_mask_q  <= '0;
      upd_q       <= 1'b1;
      player_px_q <= 1'b0;
      collide_q   <= 1'b0;
      hit_mask_q  <= '0;
      hit_index_q <= NO_HIT;
      lives_q     <= 3'(LIVES);
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_mask_q  <= acc_mask_d;
      upd_q       <= update;
      player_px_q <= w_in_box;
      collide_q   <= collide_d;
      hit_mask_q  <= hit_mask_d;
      hit_index_q <= hit_index_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
    end
  end

  assign player_px = player_px_q;
  assign collide   = collide_q;
  assign hit_mask  = hit_mask_q;
  assign hit_index = hit_index_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_collision_detector.sv
//------------------------------------------------------------------------------
// tb_maze_collision_detector : table, corner-case and random frame checks
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_maze_collision_detector;
  localparam int NW = 18;

  logic          clk = 1'b0;
  logic          rst, update;
  logic [9:0]    xCount, yCount, player_x, player_y;
  logic [NW-1:0] wall;
  logic          player_px, collide, game_over;
  logic [NW-1:0] hit_mask;
  logic [4:0]    hit_index;
  logic [2:0]    lives;

  maze_collision_detector #(
    .NUM_WALLS   (NW),
    .PLAYER_SIZE (10'd10),
    .LIVES       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .update    (update),
    .xCount    (xCount),
    .yCount    (yCount),
    .wall      (wall),
    .player_x  (player_x),
    .player_y  (player_y),
    .player_px (player_px),
    .collide   (collide),
    .hit_mask  (hit_mask),
    .hit_index (hit_index),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0]          px, py;
    int                  npix;
    logic [2:0][9:0]     x, y;
    logic [2:0][NW-1:0]  w;
    logic                e_collide;
    logic [NW-1:0]       e_mask;
    logic [4:0]          e_idx;
    logic [2:0]          e_lives;
    logic                e_go;
  } vec_t;

  vec_t tbl[11];

  logic [9:0]    fx[$], fy[$];
  logic [NW-1:0] fw[$];

  int            m_lives;
  logic          m_collide, m_go;
  logic [NW-1:0] m_mask;
  logic [4:0]    m_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_box(input logic [9:0] x, input logic [9:0] y,
                                input logic [9:0] px, input logic [9:0] py);
    int xe, ye;
    xe = (int'(px) + 10) % 1024;
    ye = (int'(py) + 10) % 1024;
    return (int'(x) > int'(px)) && (int'(x) < xe) && (int'(y) > int'(py)) && (int'(y) < ye);
  endfunction

  task automatic model_reset();
    m_lives = 3; m_collide = 1'b0; m_go = 1'b0; m_mask = '0; m_idx = 5'd31;
  endtask

  task automatic model_commit(input logic [NW-1:0] m);
    logic newc;
    if (m_go) return;
    m_mask = m;
    m_idx  = 5'd31;
    for (int i = 0; i < NW; i++) begin
      if (m[i]) begin m_idx = 5'(i); break; end
    end
    newc = (m != '0);
    if (newc && !m_collide && m_lives > 0) begin
      m_lives--;
      if (m_lives == 0) m_go = 1'b1;
    end
    m_collide = newc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Feeds fx/fy with wall lagging one cycle, then a 2-cycle update pulse.
  task automatic run_frame();
    logic [NW-1:0] acc;
    bool_loop: begin end
    acc = '0;
    for (int k = 0; k <= fx.size(); k++) begin
      xCount = (k < fx.size()) ? fx[k] : 10'd0;
      yCount = (k < fx.size()) ? fy[k] : 10'd0;
      wall   = (k > 0) ? fw[k-1] : '0;
      tick();
      if (k < fx.size()) begin
        chk("player_px", 32'(player_px), 32'(in_box(fx[k], fy[k], player_x, player_y)));
        if (in_box(fx[k], fy[k], player_x, player_y)) acc |= fw[k];
      end
    end
    xCount = 10'd0; yCount = 10'd0; wall = '0;
    tick();
    update = 1'b1;
    tick(); tick();
    update = 1'b0;
    tick();
    model_commit(acc);
  endtask

  task automatic check_outputs(input string tag, input logic ec, input logic [NW-1:0] em,
                               input logic [4:0] ei, input logic [2:0] el, input logic eg);
    chk({tag, ".collide"},   32'(collide),   32'(ec));
    chk({tag, ".hit_mask"},  32'(hit_mask),  32'(em));
    chk({tag, ".hit_index"}, 32'(hit_index), 32'(ei));
    chk({tag, ".lives"},     32'(lives),     32'(el));
    chk({tag, ".game_over"}, 32'(game_over), 32'(eg));
  endtask

  function automatic vec_t mk(input logic [9:0] px, input logic [9:0] py, input int n,
                              input logic [9:0] x0, input logic [9:0] y0, input logic [NW-1:0] w0,
                              input logic [9:0] x1, input logic [9:0] y1, input logic [NW-1:0] w1,
                              input logic [9:0] x2, input logic [9:0] y2, input logic [NW-1:0] w2,
                              input logic ec, input logic [NW-1:0] em, input logic [4:0] ei,
                              input logic [2:0] el, input logic eg);
    vec_t v;
    v.px = px; v.py = py; v.npix = n;
    v.x[0] = x0; v.y[0] = y0; v.w[0] = w0;
    v.x[1] = x1; v.y[1] = y1; v.w[1] = w1;
    v.x[2] = x2; v.y[2] = y2; v.w[2] = w2;
    v.e_collide = ec; v.e_mask = em; v.e_idx = ei; v.e_lives = el; v.e_go = eg;
    return v;
  endfunction

  initial begin
    logic [NW-1:0] ones;
    ones = '1;

    tbl[0]  = mk(300, 100, 1, 305, 105, 18'h2,   0, 0, '0,        0, 0, '0,  1'b1, 18'h2,   5'd1,  3'd2, 1'b0);
    tbl[1]  = mk(300, 100, 1, 305, 105, 18'h2,   0, 0, '0,        0, 0, '0,  1'b1, 18'h2,   5'd1,  3'd2, 1'b0);
    tbl[2]  = mk(300, 100, 1, 305, 105, 18'h2,   0, 0, '0,        0, 0, '0,  1'b1, 18'h2,   5'd1,  3'd2, 1'b0);
    tbl[3]  = mk(300, 100, 1, 305, 105, '0,      0, 0, '0,        0, 0, '0,  1'b0, '0,      5'd31, 3'd2, 1'b0);
    tbl[4]  = mk(300, 100, 2, 301, 101, 18'h10,  308, 108, 18'h200, 0, 0, '0, 1'b1, 18'h210, 5'd4,  3'd1, 1'b0);
    tbl[5]  = mk(300, 100, 1, 305, 105, '0,      0, 0, '0,        0, 0, '0,  1'b0, '0,      5'd31, 3'd1, 1'b0);
    tbl[6]  = mk(300, 100, 3, 300, 105, ones,    310, 105, ones,  305, 100, ones, 1'b0, '0, 5'd31, 3'd1, 1'b0);
    tbl[7]  = mk(1020, 100, 3, 2, 105, ones,     5, 105, ones,    1023, 105, ones, 1'b0, '0, 5'd31, 3'd1, 1'b0);
    tbl[8]  = mk(300, 100, 1, 309, 109, 18'h3,   0, 0, '0,        0, 0, '0,  1'b1, 18'h3,   5'd0,  3'd0, 1'b1);
    tbl[9]  = mk(300, 100, 1, 305, 105, 18'h20000, 0, 0, '0,      0, 0, '0,  1'b1, 18'h3,   5'd0,  3'd0, 1'b1);
    tbl[10] = mk(300, 100, 1, 305, 105, '0,      0, 0, '0,        0, 0, '0,  1'b1, 18'h3,   5'd0,  3'd0, 1'b1);

    rst = 1'b1; update = 1'b0; xCount = '0; yCount = '0; wall = '0;
    player_x = 10'd300; player_y = 10'd100;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    chk("reset.player_px", 32'(player_px), 32'd0);
    check_outputs("reset", 1'b0, '0, 5'd31, 3'd3, 1'b0);

    for (int i = 0; i < 11; i++) begin
      player_x = tbl[i].px; player_y = tbl[i].py;
      fx.delete(); fy.delete(); fw.delete();
      for (int p = 0; p < tbl[i].npix; p++) begin
        fx.push_back(tbl[i].x[p]); fy.push_back(tbl[i].y[p]); fw.push_back(tbl[i].w[p]);
      end
      run_frame();
      check_outputs($sformatf("vec%0d", i), tbl[i].e_collide, tbl[i].e_mask,
                    tbl[i].e_idx, tbl[i].e_lives, tbl[i].e_go);
    end

    // Reset leaves OVER; a hit seen before a mid-frame reset is discarded.
    do_reset();
    check_outputs("rst_from_over", 1'b0, '0, 5'd31, 3'd3, 1'b0);
    player_x = 10'd300; player_y = 10'd100;
    xCount = 10'd305; yCount = 10'd105; wall = '0;
    tick();
    xCount = 10'd0; yCount = 10'd0; wall = 18'h20;
    tick();
    wall = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    fx = '{10'd305}; fy = '{10'd105}; fw = '{18'h0};
    run_frame();
    check_outputs("midframe_rst", 1'b0, '0, 5'd31, 3'd3, 1'b0);

    // update held high across reset release must not produce a commit.
    update = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    tick(); tick(); tick();
    check_outputs("upd_high_release", 1'b0, '0, 5'd31, 3'd3, 1'b0);
    update = 1'b0;
    tick();
    fx = '{10'd305}; fy = '{10'd105}; fw = '{18'h80};
    run_frame();
    check_outputs("pulse2", 1'b1, 18'h80, 5'd7, 3'd2, 1'b0);
    tick(); tick(); tick();
    check_outputs("pulse2_hold", 1'b1, 18'h80, 5'd7, 3'd2, 1'b0);

    // Random frames against the reference model.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int np;
      if (m_go && ($urandom_range(0, 1) == 1)) do_reset();
      player_x = 10'($urandom_range(0, 1023));
      player_y = 10'($urandom_range(0, 1023));
      fx.delete(); fy.delete(); fw.delete();
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        fx.push_back(10'(player_x + $urandom_range(0, 11)));
        fy.push_back(10'(player_y + $urandom_range(0, 11)));
        case ($urandom_range(0, 3))
          0:       fw.push_back('0);
          1:       fw.push_back(NW'($urandom));
          default: fw.push_back(NW'(1) << $urandom_range(0, NW - 1));
        endcase
      end
      run_frame();
      check_outputs($sformatf("rand%0d", f), m_collide, m_mask, m_idx, 3'(m_lives), m_go);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
